serial_memory_target: RTL and testbench
=======================================

Name: serial_memory_target

Overview:
- Single-clock responder for the serial shift-register memory bus, i.e. the far end of the controller's ser_clk/ser_out/ser_in loop.
- Emulates a daisy chain of NUM_WORDS shift registers, each DATA_WIDTH bits wide, in synthesizable registers.
- Adds a parallel read-back port, a word-boundary strobe and a synchronous clear.
- Used on-chip in place of external 595-style parts, and as a bus-functional target for controller verification.

Parameters:
DATA_WIDTH, 8, bits per word.
NUM_WORDS, 4, words in the chain (>=1).
ADDRESS_WIDTH, 4, width of rd_addr and word_count; 2**ADDRESS_WIDTH >= NUM_WORDS.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
ser_clk  in  1  serial shift clock from the controller, same clock domain, level-sampled.
ser_in  in  1  serial data into word 0 (the controller's ser_out).
ser_out  out  1  serial data out of word NUM_WORDS-1 (to the controller's ser_in).
clr  in  1  synchronous clear of storage and counters.
rd_req  in  1  parallel read request, single-cycle.
rd_addr  in  ADDRESS_WIDTH  word index for the read.
rd_valid  out  1  one-cycle pulse carrying rd_data.
rd_data  out  DATA_WIDTH  word read.
rd_err  out  1  qualifies rd_valid: rd_addr >= NUM_WORDS.
word_strobe  out  1  one-cycle pulse after every DATA_WIDTH shifts.
word_count  out  ADDRESS_WIDTH  completed words modulo NUM_WORDS.

Behaviour:
- Reset (rst_n=0, asynchronous): storage all 0, ser_out=0, rd_valid=0, rd_data=0, rd_err=0, word_strobe=0, word_count=0, bit counter=0, ser_clk_q=0.
- Edge detect: register ser_clk_q <= ser_clk each cycle; shift_en = ser_clk & ~ser_clk_q.
- ser_clk is held level: at most one shift per low-to-high transition, however long the high phase lasts.
- Shift (on a cycle with shift_en):
  - word[0] <= {ser_in, word[0][DATA_WIDTH-1:1]}
  - word[i] <= {word[i-1][0], word[i][DATA_WIDTH-1:1]} for i >= 1
  - Word MSB is the entry bit; the LSB moves onward.
- ser_out is registered: it equals word[NUM_WORDS-1][0] of the current storage.
  - Its value before a shift is the bit the controller samples for that shift.
  - It updates in the same cycle as the storage.
- Bit counter, 0..DATA_WIDTH-1:
  - Increments on shift_en.
  - On the shift that takes it from DATA_WIDTH-1 to 0: word_strobe=1 the next cycle, and word_count increments.
  - word_count wraps NUM_WORDS-1 -> 0.
- Read, latency 1:
  - rd_req in cycle N gives rd_valid=1 in cycle N+1.
  - rd_data = word[rd_addr] as it was at the start of cycle N, i.e. pre-shift if shift_en is also active in N.
  - rd_req is accepted every cycle; back-to-back reads are allowed.
  - Out-of-range rd_addr: rd_data=0 and rd_err=1, both with rd_valid.
  - rd_data holds its value when rd_valid=0.
- clr=1:
  - Next cycle: storage=0, ser_out=0, bit counter=0, word_count=0, word_strobe=0.
  - clr overrides a simultaneous shift.
  - A read in the same cycle returns pre-clear data.
  - ser_clk_q keeps tracking ser_clk, so a high ser_clk held through clr does not cause a spurious shift.
- Reset asserted mid-word: everything returns to reset values immediately. The partially shifted word is discarded.
- Loop semantics: after NUM_WORDS*DATA_WIDTH shifts with ser_in tied to ser_out, storage equals its original contents. This is the controller's "loop" operation.

Test Plan:
1. Reset, then rd_req for addr 0..3 -> rd_valid one cycle later each, rd_data=0x00, rd_err=0, ser_out=0, word_count=0.
2. Shift in 0xD6 LSB-first with ser_clk held high for 3 cycles per bit -> exactly 8 shifts; word[0]=0xD6; one word_strobe; word_count=1.
3. Shift in 0x07, 0x63, 0x99, 0x3C in that order -> word[0..3]=0x3C,0x99,0x63,0x07; ser_out bit stream starts 1,1,1,0.
4. Loopback ser_in=ser_out for 32 shifts -> contents unchanged; four word_strobe pulses; word_count back to 0.
5. rd_req addr 3 on the same cycle as a shift edge -> rd_data=0x07 (pre-shift); rd_addr=5 -> rd_err=1, rd_data=0x00.
6. clr during bit 4 of a word with ser_clk high -> all words 0, bit counter 0, no extra shift after clr. rst_n pulse mid-word -> same result, asynchronously.

Source files
------------

// File: rtl/serial_memory_target.sv
// Far-end target for the serial shift-register memory bus: a NUM_WORDS x DATA_WIDTH
// shift chain with a parallel read-back port, a word-boundary strobe and a synchronous clear.
module serial_memory_target #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_WORDS     = 4,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ser_clk,
    input  logic                     ser_in,
    output logic                     ser_out,
    input  logic                     clr,
    input  logic                     rd_req,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_err,
    output logic                     word_strobe,
    output logic [ADDRESS_WIDTH-1:0] word_count
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]         BIT_LAST      = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_LAST     = ADDRESS_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDRESS_WIDTH:0]   NUM_WORDS_EXT = (ADDRESS_WIDTH + 1)'(NUM_WORDS);

    logic [DATA_WIDTH-1:0]    mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0]    mem_d [NUM_WORDS];
    logic                     ser_clk_q, ser_clk_d;
    logic                     ser_out_q, ser_out_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [ADDRESS_WIDTH-1:0] word_count_q, word_count_d;
    logic                     word_strobe_q, word_strobe_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                     rd_err_q, rd_err_d;
    logic                     shift_en;
    logic                     rd_in_range;
    logic [DATA_WIDTH-1:0]    rd_sel;

    // ser_clk_q follows ser_clk unconditionally so a level held across clr never re-triggers.
    always_comb begin
        ser_clk_d     = ser_clk;
        shift_en      = ser_clk & ~ser_clk_q;
        mem_d         = mem_q;
        bit_cnt_d     = bit_cnt_q;
        word_count_d  = word_count_q;
        word_strobe_d = 1'b0;

        if (clr) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_d[i] = '0;
            end
            bit_cnt_d    = '0;
            word_count_d = '0;
        end else if (shift_en) begin
            mem_d[0] = {ser_in, mem_q[0][DATA_WIDTH-1:1]};
            for (int i = 1; i < NUM_WORDS; i++) begin
                mem_d[i] = {mem_q[i-1][0], mem_q[i][DATA_WIDTH-1:1]};
            end
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d     = '0;
                word_strobe_d = 1'b1;
                word_count_d  = (word_count_q == WORD_LAST) ? '0 : word_count_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // Registered from next storage so ser_out always mirrors the current tail bit.
        ser_out_d = mem_d[NUM_WORDS-1][0];
    end

    // Reads sample storage before this cycle's shift or clear takes effect.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_addr == ADDRESS_WIDTH'(i)) begin
                rd_sel = mem_q[i];
            end
        end
        rd_in_range = ({1'b0, rd_addr} < NUM_WORDS_EXT);
        rd_valid_d  = rd_req;
        rd_data_d   = rd_data_q;
        rd_err_d    = 1'b0;
        if (rd_req) begin
            rd_data_d = rd_in_range ? rd_sel : '0;
            rd_err_d  = ~rd_in_range;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            ser_clk_q     <= 1'b0;
            ser_out_q     <= 1'b0;
            bit_cnt_q     <= '0;
            word_count_q  <= '0;
            word_strobe_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_err_q      <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            ser_clk_q     <= ser_clk_d;
            ser_out_q     <= ser_out_d;
            bit_cnt_q     <= bit_cnt_d;
            word_count_q  <= word_count_d;
            word_strobe_q <= word_strobe_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            rd_err_q      <= rd_err_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_err      = rd_err_q;
    assign word_strobe = word_strobe_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_serial_memory_target.sv
// Directed and randomized bench for serial_memory_target; the chain is modelled as one
// long bit vector with word 0 at the top, plus a running shift count.
module tb_serial_memory_target;

    localparam int DW  = 8;
    localparam int NW  = 4;
    localparam int AW  = 4;
    localparam int TOT = NW * DW;

    logic          clk;
    logic          rst_n;
    logic          ser_clk;
    logic          ser_in;
    logic          ser_out;
    logic          clr;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          word_strobe;
    logic [AW-1:0] word_count;

    serial_memory_target #(
        .DATA_WIDTH(DW), .NUM_WORDS(NW), .ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_in(ser_in), .ser_out(ser_out),
        .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err), .word_strobe(word_strobe), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int strobes_seen = 0;

    // Reference model state
    logic [TOT-1:0] m_chain;
    int             m_shifts;
    logic           m_sclk;
    logic           m_strobe;
    logic           m_rd_valid;
    logic [DW-1:0]  m_rd_data;
    logic           m_rd_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        return m_chain[(NW-1-i)*DW +: DW];
    endfunction

    task automatic model_reset();
        m_chain    = '0;
        m_shifts   = 0;
        m_sclk     = 1'b0;
        m_strobe   = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
        m_rd_err   = 1'b0;
    endtask

    // One clock: advance the model from the applied inputs, then compare after the edge.
    task automatic tick();
        bit sh;
        sh = ser_clk && !m_sclk;
        m_sclk = ser_clk;
        m_rd_valid = rd_req;
        if (rd_req) begin
            if (int'(rd_addr) < NW) begin
                m_rd_data = word_of(int'(rd_addr));
                m_rd_err  = 1'b0;
            end else begin
                m_rd_data = '0;
                m_rd_err  = 1'b1;
            end
        end
        m_strobe = 1'b0;
        if (clr) begin
            m_chain  = '0;
            m_shifts = 0;
        end else if (sh) begin
            m_chain = {ser_in, m_chain[TOT-1:1]};
            m_shifts++;
            if (m_shifts % DW == 0) m_strobe = 1'b1;
        end
        @(posedge clk);
        #1;
        if (word_strobe) strobes_seen++;
        check("ser_out", ser_out, m_chain[0]);
        check("word_strobe", word_strobe, m_strobe);
        check("word_count", word_count, (m_shifts / DW) % NW);
        check("rd_valid", rd_valid, m_rd_valid);
        check("rd_data", rd_data, m_rd_data);
        if (m_rd_valid) check("rd_err", rd_err, m_rd_err);
    endtask

    task automatic shift_bit(input logic b, input int hi_cycles);
        ser_in  = b;
        ser_clk = 1'b1;
        repeat (hi_cycles) tick();
        ser_clk = 1'b0;
        tick();
    endtask

    task automatic shift_byte(input logic [DW-1:0] v, input int hi_cycles);
        for (int b = 0; b < DW; b++) shift_bit(v[b], hi_cycles);
    endtask

    task automatic read_word(input int addr, output logic [DW-1:0] data, output logic err);
        rd_req  = 1'b1;
        rd_addr = AW'(addr);
        tick();
        rd_req = 1'b0;
        data = rd_data;
        err  = rd_err;
    endtask

    logic [DW-1:0] rdv;
    logic          rde;
    logic [3:0]    stream;
    logic [DW-1:0] exp_words [NW];
    int            s0;
    logic          lb;

    initial begin
        rst_n = 1'b0; ser_clk = 1'b0; ser_in = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ser_out", ser_out, 0);
        check("reset_word_count", word_count, 0);
        check("reset_strobe", word_strobe, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // Reads of a freshly reset chain
        for (int a = 0; a < NW; a++) begin
            read_word(a, rdv, rde);
            check("init_read_data", rdv, 0);
            check("init_read_err", rde, 0);
        end

        // Held-high ser_clk: one shift per rising edge
        s0 = strobes_seen;
        shift_byte(8'hD6, 3);
        read_word(0, rdv, rde);
        check("d6_word0", rdv, 8'hD6);
        check("d6_strobes", strobes_seen - s0, 1);
        check("d6_word_count", word_count, 1);

        clr = 1'b1; tick(); clr = 1'b0; tick();

        shift_byte(8'h07, 1);
        shift_byte(8'h63, 1);
        shift_byte(8'h99, 1);
        shift_byte(8'h3C, 2);
        exp_words[0] = 8'h3C; exp_words[1] = 8'h99; exp_words[2] = 8'h63; exp_words[3] = 8'h07;
        for (int a = 0; a < NW; a++) begin
            read_word(a, rdv, rde);
            check("fill_word", rdv, exp_words[a]);
        end
        check("fill_word_count", word_count, 0);

        // Loopback: ser_in follows ser_out for a full rotation
        stream = 4'b0111;
        s0 = strobes_seen;
        for (int k = 0; k < TOT; k++) begin
            lb = m_chain[0];
            if (k < 4) check("stream", ser_out, stream[k]);
            shift_bit(lb, 1);
        end
        for (int a = 0; a < NW; a++) begin
            read_word(a, rdv, rde);
            check("loop_word", rdv, exp_words[a]);
        end
        check("loop_strobes", strobes_seen - s0, 4);
        check("loop_word_count", word_count, 0);

        // Read coinciding with a shift edge returns pre-shift data
        ser_in = 1'b0; ser_clk = 1'b1; rd_req = 1'b1; rd_addr = 4'd3;
        tick();
        rd_req = 1'b0; ser_clk = 1'b0;
        check("read_preshift", rd_data, 8'h07);
        tick();
        read_word(5, rdv, rde);
        check("oor_data", rdv, 0);
        check("oor_err", rde, 1);

        // clr on a shift edge partway through a word, ser_clk stays high afterwards
        shift_bit(1'b1, 1); shift_bit(1'b0, 1); shift_bit(1'b1, 1);
        ser_clk = 1'b1; ser_in = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick();
        ser_clk = 1'b0;
        tick();
        for (int a = 0; a < NW; a++) begin
            read_word(a, rdv, rde);
            check("clr_word", rdv, 0);
        end
        check("clr_word_count", word_count, 0);
        s0 = strobes_seen;
        for (int b = 0; b < DW - 1; b++) shift_bit(1'b1, 1);
        check("clr_no_early_strobe", strobes_seen - s0, 0);
        shift_bit(1'b1, 1);
        check("clr_strobe_after_8", strobes_seen - s0, 1);

        // Asynchronous reset mid-word
        shift_bit(1'b1, 1); shift_bit(1'b1, 1); shift_bit(1'b0, 1); shift_bit(1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ser_out", ser_out, 0);
        check("arst_word_count", word_count, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_rd_valid", rd_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < NW; a++) begin
            read_word(a, rdv, rde);
            check("arst_word", rdv, 0);
        end
        s0 = strobes_seen;
        for (int b = 0; b < DW - 1; b++) shift_bit(1'b0, 1);
        check("arst_no_early_strobe", strobes_seen - s0, 0);
        shift_bit(1'b1, 1);
        check("arst_strobe_after_8", strobes_seen - s0, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ser_clk = 1'($urandom_range(0, 1));
            ser_in  = 1'($urandom_range(0, 1));
            rd_req  = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 7));
            clr     = ($urandom_range(0, 40) == 0);
            tick();
        end
        ser_clk = 1'b0; rd_req = 1'b0; clr = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
